// File: rtl/rbm_vote_controller.sv
// Iteration/vote controller for the stochastic RBM classifier: re-runs the layers, keeps saturating
// per-class vote counters, registers the arg-max class. Define EARLY_EXIT_EN to enable the margin exit.
module rbm_vote_controller #(
  parameter int OUTPUT_DIM = 10,
  parameter int CNT_W      = 12,
  parameter int ITER_W     = 10,
  parameter int CLS_W      = 4
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic                        start,
  input  logic [ITER_W-1:0]           iter_count,
  input  logic [CNT_W-1:0]            margin,
  output logic                        layer_rst,
  input  logic                        layer_done,
  input  logic [OUTPUT_DIM-1:0]       layer_out,
  output logic [OUTPUT_DIM*CNT_W-1:0] votes,
  output logic [CLS_W-1:0]            winner,
  output logic [ITER_W-1:0]           iter_done,
  output logic                        busy,
  output logic                        finish,
  output logic                        early_exit
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LRST  = 3'd1,
    S_RUN   = 3'd2,
    S_ACCUM = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t             r_state;
  state_t             w_next;
  logic [CNT_W-1:0]   r_votes [OUTPUT_DIM];
  logic [ITER_W-1:0]  r_iter_target;
  logic [ITER_W-1:0]  r_iter_done;
  logic [CLS_W-1:0]   r_winner;
  logic               r_layer_rst;
  logic               r_busy;
  logic               r_finish;
  logic               w_accept;
  logic [CNT_W-1:0]   w_top;
  logic [CLS_W-1:0]   w_top_idx;
`ifdef EARLY_EXIT_EN
  logic [CNT_W-1:0]   r_margin;
  logic               r_early_exit;
  logic [CNT_W-1:0]   w_second;
  logic               w_margin_hit;
`else
  logic               w_unused_margin;
  assign w_unused_margin = ^margin;
`endif

  // Arg-max over the counters; strict compare keeps ties on the lowest index.
  always_comb begin
    w_top     = '0;
    w_top_idx = '0;
`ifdef EARLY_EXIT_EN
    w_second  = '0;
`endif
    for (int i = 0; i < OUTPUT_DIM; i++) begin
      if (r_votes[i] > w_top) begin
`ifdef EARLY_EXIT_EN
        w_second  = w_top;
`endif
        w_top     = r_votes[i];
        w_top_idx = CLS_W'(i);
      end else begin
`ifdef EARLY_EXIT_EN
        if (r_votes[i] > w_second) begin
          w_second = r_votes[i];
        end else begin
          w_second = w_second;
        end
`else
        w_top = w_top;
`endif
      end
    end
  end

`ifdef EARLY_EXIT_EN
  assign w_margin_hit = (r_margin != '0) && ((w_top - w_second) >= r_margin);
`endif

  // Next-state decode.
  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_accept = 1'b1;
          w_next   = (iter_count == '0) ? S_DONE : S_LRST;
        end else begin
          w_next = r_state;
        end
      end
      S_LRST:  w_next = S_RUN;
      S_RUN: begin
        if (layer_done) begin
          w_next = S_ACCUM;
        end else begin
          w_next = S_RUN;
        end
      end
      S_ACCUM: begin
        if (r_iter_done == r_iter_target) begin
          w_next = S_DONE;
`ifdef EARLY_EXIT_EN
        end else if (w_margin_hit) begin
          w_next = S_DONE;
`endif
        end else begin
          w_next = S_LRST;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // State, status flags, counters and winner register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= S_IDLE;
      r_layer_rst   <= 1'b1;
      r_busy        <= 1'b0;
      r_finish      <= 1'b0;
      r_winner      <= '0;
      r_iter_done   <= '0;
      r_iter_target <= '0;
      for (int i = 0; i < OUTPUT_DIM; i++) r_votes[i] <= '0;
    end else begin
      r_state     <= w_next;
      // The reset-time layer hold persists through IDLE until the first start.
      r_layer_rst <= (w_next == S_LRST) ||
                     (r_layer_rst && (r_state == S_IDLE) && (w_next == S_IDLE));
      r_busy      <= (w_next == S_LRST) || (w_next == S_RUN) || (w_next == S_ACCUM);
      r_finish    <= (w_next == S_DONE);
      if (w_accept) begin
        r_winner      <= '0;
        r_iter_done   <= '0;
        r_iter_target <= iter_count;
        for (int i = 0; i < OUTPUT_DIM; i++) r_votes[i] <= '0;
      end else if ((r_state == S_RUN) && layer_done) begin
        r_iter_done <= r_iter_done + ITER_W'(1);
        for (int i = 0; i < OUTPUT_DIM; i++) begin
          if (layer_out[i] && (r_votes[i] != CNT_MAX)) r_votes[i] <= r_votes[i] + CNT_W'(1);
        end
      end else if (r_state == S_ACCUM) begin
        r_winner <= w_top_idx;
      end
    end
  end

`ifdef EARLY_EXIT_EN
  // Margin latch and early-exit flag.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_margin     <= '0;
      r_early_exit <= 1'b0;
    end else if (w_accept) begin
      r_margin     <= margin;
      r_early_exit <= 1'b0;
    end else if ((r_state == S_ACCUM) && (r_iter_done != r_iter_target) && w_margin_hit) begin
      r_early_exit <= 1'b1;
    end
  end
  assign early_exit = r_early_exit;
`else
  assign early_exit = 1'b0;
`endif

  // Pack the counter array onto the flat votes bus.
  always_comb begin
    votes = '0;
    for (int i = 0; i < OUTPUT_DIM; i++) votes[i*CNT_W +: CNT_W] = r_votes[i];
  end

  assign layer_rst = r_layer_rst;
  assign busy      = r_busy;
  assign finish    = r_finish;
  assign winner    = r_winner;
  assign iter_done = r_iter_done;

endmodule

// File: tb/tb_rbm_vote_controller.sv
// Directed bench for rbm_vote_controller: one default instance plus a CNT_W=3 instance for saturation.
module tb_rbm_vote_controller;
  localparam int OD = 10, CW = 12, IW = 10, LW = 4, CW2 = 3, LIMIT = 2000;

  logic                clock = 1'b0;
  logic                reset_n;
  logic                start, start2;
  logic [IW-1:0]       iter_count, iter_count2;
  logic [CW-1:0]       margin;
  logic [CW2-1:0]      margin2;
  logic [OD-1:0]       layer_out, layer_out2;
  logic                layer_rst, layer_rst2, layer_done, layer_done2;
  logic [OD*CW-1:0]    votes;
  logic [OD*CW2-1:0]   votes2;
  logic [LW-1:0]       winner, winner2;
  logic [IW-1:0]       iter_done, iter_done2;
  logic                busy, busy2, finish, finish2, early_exit, early_exit2;
  logic [7:0]          lcnt = 8'd0, lcnt2 = 8'd0;
  logic [OD*CW-1:0]    exp_votes;
  logic [OD*CW2-1:0]   exp_votes2;
  int                  checks = 0, errors = 0, cyc, n;

  always #5 clock = ~clock;

  rbm_vote_controller #(.OUTPUT_DIM(OD), .CNT_W(CW), .ITER_W(IW), .CLS_W(LW)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .iter_count(iter_count), .margin(margin),
    .layer_rst(layer_rst), .layer_done(layer_done), .layer_out(layer_out), .votes(votes),
    .winner(winner), .iter_done(iter_done), .busy(busy), .finish(finish), .early_exit(early_exit));

  rbm_vote_controller #(.OUTPUT_DIM(OD), .CNT_W(CW2), .ITER_W(IW), .CLS_W(LW)) dut2 (
    .clock(clock), .reset_n(reset_n), .start(start2), .iter_count(iter_count2), .margin(margin2),
    .layer_rst(layer_rst2), .layer_done(layer_done2), .layer_out(layer_out2), .votes(votes2),
    .winner(winner2), .iter_done(iter_done2), .busy(busy2), .finish(finish2), .early_exit(early_exit2));

  // Layer stand-in: done is seen on the 4th RUN cycle after layer_rst drops.
  always @(posedge clock) begin
    if (layer_rst) lcnt <= 8'd0;
    else if (lcnt != 8'hFF) lcnt <= lcnt + 8'd1;
    if (layer_rst2) lcnt2 <= 8'd0;
    else if (lcnt2 != 8'hFF) lcnt2 <= lcnt2 + 8'd1;
  end
  assign layer_done  = !layer_rst  && (lcnt  == 8'd3);
  assign layer_done2 = !layer_rst2 && (lcnt2 == 8'd3);

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_start(input logic [IW-1:0] it, input logic [CW-1:0] mg);
    @(negedge clock);
    start = 1'b1; iter_count = it; margin = mg;
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  task automatic wait_finish(input string tag, output int cycles);
    int k;
    k = 1;
    while (!finish && k < LIMIT) begin
      @(posedge clock); #1;
      k++;
    end
    cycles = k;
    chk(tag, 128'(finish), 128'(1));
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; start2 = 1'b0;
    iter_count = '0; iter_count2 = '0; margin = '0; margin2 = '0;
    layer_out = '0; layer_out2 = '0;
    repeat (2) @(posedge clock); #1;
    chk("rst_layer_rst", 128'(layer_rst), 128'(1));
    chk("rst_outputs", 128'({busy, finish, early_exit, winner, iter_done}), 128'(0));
    chk("rst_votes", 128'(votes), 128'(0));
    @(negedge clock) reset_n = 1'b1;

    // Basic run: classes 0 and 3 fire each of 5 iterations.
    layer_out = 10'b0000001001;
    do_start(10'd5, 12'd0);
    chk("basic_busy_rise", 128'(busy), 128'(1));
    wait_finish("basic_finish", cyc);
    chk("basic_cycles", 128'(cyc), 128'(31));
    exp_votes = '0;
    exp_votes[0*CW +: CW] = 12'd5;
    exp_votes[3*CW +: CW] = 12'd5;
    chk("basic_votes", 128'(votes), 128'(exp_votes));
    chk("basic_winner", 128'(winner), 128'(0));
    chk("basic_iter_done", 128'(iter_done), 128'(5));
    chk("basic_busy_low", 128'({busy, early_exit}), 128'(0));

    // Back-to-back restart from DONE, with a start pulse during RUN that must be ignored.
    layer_out = 10'b0000100000;
    do_start(10'd2, 12'd0);
    chk("restart_edge", 128'({finish, busy}), 128'(2'b01));
    chk("restart_cleared", 128'({votes, iter_done}), 128'(0));
    repeat (3) @(posedge clock);
    do_start(10'd0, 12'd0);
    chk("ignored_start", 128'({busy, finish}), 128'(2'b10));
    wait_finish("restart_finish", cyc);
    exp_votes = '0;
    exp_votes[5*CW +: CW] = 12'd2;
    chk("restart_votes", 128'(votes), 128'(exp_votes));
    chk("restart_winner", 128'(winner), 128'(5));
    chk("restart_iter_done", 128'(iter_done), 128'(2));

    // Margin run: only class 7 fires, margin 4, 100 iterations requested.
    layer_out = 10'b0010000000;
    do_start(10'd100, 12'd4);
    wait_finish("early_finish", cyc);
    exp_votes = '0;
`ifdef EARLY_EXIT_EN
    exp_votes[7*CW +: CW] = 12'd4;
    chk("early_iter_done", 128'(iter_done), 128'(4));
    chk("early_flag", 128'(early_exit), 128'(1));
`else
    exp_votes[7*CW +: CW] = 12'd100;
    chk("early_iter_done", 128'(iter_done), 128'(100));
    chk("early_flag", 128'(early_exit), 128'(0));
`endif
    chk("early_votes", 128'(votes), 128'(exp_votes));
    chk("early_winner", 128'(winner), 128'(7));

    // Tie and saturation on the 3-bit-counter instance.
    layer_out2 = 10'b1000000100;
    @(negedge clock);
    start2 = 1'b1; iter_count2 = 10'd10;
    @(posedge clock); #1;
    start2 = 1'b0;
    n = 1;
    while (!finish2 && n < LIMIT) begin
      @(posedge clock); #1;
      n++;
    end
    chk("sat_finish", 128'(finish2), 128'(1));
    exp_votes2 = '0;
    exp_votes2[2*CW2 +: CW2] = 3'd7;
    exp_votes2[9*CW2 +: CW2] = 3'd7;
    chk("sat_votes", 128'(votes2), 128'(exp_votes2));
    chk("sat_winner", 128'(winner2), 128'(2));
    chk("sat_iter_done", 128'(iter_done2), 128'(10));

    // Asynchronous reset in the RUN phase of iteration 3.
    layer_out = 10'b0000001001;
    do_start(10'd5, 12'd0);
    n = 1;
    while (iter_done != 10'd2 && n < LIMIT) begin
      @(posedge clock); #1;
      n++;
    end
    chk("midrun_reached", 128'(iter_done), 128'(2));
    repeat (2) @(posedge clock); #1;
    chk("midrun_in_run", 128'({busy, layer_rst}), 128'(2'b10));
    #2 reset_n = 1'b0;
    #1;
    chk("midrun_rst_layer", 128'(layer_rst), 128'(1));
    chk("midrun_rst_outputs", 128'({busy, finish, early_exit, winner, iter_done}), 128'(0));
    chk("midrun_rst_votes", 128'(votes), 128'(0));
    @(negedge clock) reset_n = 1'b1;

    // Zero-iteration start from IDLE: straight to DONE, busy never rises.
    do_start(10'd0, 12'd0);
    chk("zero_finish", 128'({finish, busy}), 128'(2'b10));
    chk("zero_cleared", 128'({votes, iter_done}), 128'(0));
    do_start(10'd1, 12'd0);
    chk("idle_start_busy", 128'({busy, finish}), 128'(2'b10));
    wait_finish("one_finish", cyc);
    chk("one_cycles", 128'(cyc), 128'(7));
    chk("one_iter_done", 128'(iter_done), 128'(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
